// File: rtl/pkt_cache_reader.sv
// pkt_cache_reader
//   Streams one cache slot (16 slots x 128 words x 134 bit) out as a head/body/tail packet.
//   Takes a packet ID from the scheduler, reads the slot word by word, forwards returned
//   words up to and including the tail, then returns the ID to the free pool together with
//   a packet-good flag.
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   in_pkt_id/_wr, out_pkt_id_ready
//                               ID handshake; an ID is taken only while ready=1
//   ram_raddr, ram_rd, ram_rdata
//                               cache read port, data returns RAM_LAT cycles after ram_rd
//   in_pkt_alf                  downstream almost-full, pauses new reads
//   out_pkt_data/_wr            packet words; [133:132] 01 head, 11 body, 10 tail
//   out_pkt_valid/_wr           packet good/bad flag, pulsed together with the release
//   out_id_release/_wr          ID handed back to the free pool, one pulse per packet
module pkt_cache_reader #(
   parameter int RAM_LAT    = 2,
   parameter int SLOT_WORDS = 128
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   in_pkt_id,
   input  logic         in_pkt_id_wr,
   output logic         out_pkt_id_ready,
   output logic [10:0]  ram_raddr,
   output logic         ram_rd,
   input  logic [133:0] ram_rdata,
   input  logic         in_pkt_alf,
   output logic [133:0] out_pkt_data,
   output logic         out_pkt_data_wr,
   output logic         out_pkt_valid,
   output logic         out_pkt_valid_wr,
   output logic [7:0]   out_id_release,
   output logic         out_id_release_wr
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_READ    = 2'd1;
   localparam logic [1:0] S_DRAIN   = 2'd2;
   localparam logic [1:0] S_RELEASE = 2'd3;

   localparam logic [6:0] LAST_IDX  = 7'(SLOT_WORDS - 1);

   localparam logic [1:0] F_HEAD    = 2'b01;
   localparam logic [1:0] F_TAIL    = 2'b10;

   logic [1:0]         state;
   logic [7:0]         id_q;
   logic [6:0]         word_idx;   // next word to request
   logic [6:0]         ret_idx;    // index of the word currently returning
   logic               tail_seen;
   logic               err;
   logic [2:0]         inflight;
   logic [RAM_LAT:1]   rd_pipe;    // ram_rd delayed to line up with ram_rdata

   logic               ret_vld;
   logic [1:0]         ret_flags;
   logic               head_bad;
   logic               emit;
   logic               force_tail;
   logic               rel;

   assign ret_vld    = rd_pipe[RAM_LAT];
   assign ret_flags  = ram_rdata[133:132];
   assign head_bad   = ret_vld && (ret_idx == 7'd0) && (ret_flags != F_HEAD);
   // Once the tail is through (or the packet is known bad) every further word is an over-read.
   assign emit       = ret_vld && !tail_seen && !err && !head_bad;
   // The last slot word closes the packet even when the writer never marked a tail.
   assign force_tail = (ret_idx == LAST_IDX) && (ret_flags != F_TAIL);

   assign out_pkt_id_ready = (state == S_IDLE);
   assign ram_rd           = (state == S_READ) && !in_pkt_alf && !tail_seen;
   assign ram_raddr        = {id_q[3:0], word_idx};

   assign out_pkt_data_wr  = emit;
   assign out_pkt_data     = !emit      ? '0 :
                             force_tail ? {F_TAIL, ram_rdata[131:0]} : ram_rdata;

   assign rel               = (state == S_RELEASE);
   assign out_id_release_wr = rel;
   assign out_id_release    = rel ? id_q : 8'd0;
   assign out_pkt_valid_wr  = rel;
   assign out_pkt_valid     = rel && !err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pipe <= '0;
      end else begin
         rd_pipe[1] <= ram_rd;
         for (int i = 2; i <= RAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         id_q      <= '0;
         word_idx  <= '0;
         ret_idx   <= '0;
         tail_seen <= 1'b0;
         err       <= 1'b0;
         inflight  <= '0;
      end else begin
         inflight <= inflight + {2'b00, ram_rd} - {2'b00, ret_vld};
         if (ram_rd) word_idx <= word_idx + 7'd1;
         if (ret_vld) begin
            ret_idx <= ret_idx + 7'd1;
            // Any returned tail ends reading, including one inside a packet already marked bad.
            if (ret_flags == F_TAIL) tail_seen <= 1'b1;
         end
         if (head_bad || (emit && force_tail)) err <= 1'b1;

         case (state)
            S_IDLE: begin
               if (in_pkt_id_wr) begin
                  id_q      <= in_pkt_id;
                  word_idx  <= '0;
                  ret_idx   <= '0;
                  tail_seen <= 1'b0;
                  err       <= 1'b0;
                  inflight  <= '0;
                  state     <= S_READ;
               end
            end
            S_READ: begin
               if (tail_seen || (ram_rd && word_idx == LAST_IDX)) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (inflight == 3'd0) state <= S_RELEASE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pkt_cache_reader.sv
module tb_pkt_cache_reader;
   localparam int RAM_LAT = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   in_pkt_id;
   logic         in_pkt_id_wr;
   logic         out_pkt_id_ready;
   logic [10:0]  ram_raddr;
   logic         ram_rd;
   logic [133:0] ram_rdata;
   logic         in_pkt_alf;
   logic [133:0] out_pkt_data;
   logic         out_pkt_data_wr;
   logic         out_pkt_valid;
   logic         out_pkt_valid_wr;
   logic [7:0]   out_id_release;
   logic         out_id_release_wr;

   pkt_cache_reader #(.RAM_LAT(RAM_LAT), .SLOT_WORDS(128)) dut (
      .clk(clk), .rst(rst),
      .in_pkt_id(in_pkt_id), .in_pkt_id_wr(in_pkt_id_wr), .out_pkt_id_ready(out_pkt_id_ready),
      .ram_raddr(ram_raddr), .ram_rd(ram_rd), .ram_rdata(ram_rdata),
      .in_pkt_alf(in_pkt_alf),
      .out_pkt_data(out_pkt_data), .out_pkt_data_wr(out_pkt_data_wr),
      .out_pkt_valid(out_pkt_valid), .out_pkt_valid_wr(out_pkt_valid_wr),
      .out_id_release(out_id_release), .out_id_release_wr(out_id_release_wr)
   );

   always #5 clk = ~clk;

   // Cache RAM model: address registered RAM_LAT times, data read from the delayed address.
   logic [133:0] mem [16][128];
   logic [10:0]  ap [RAM_LAT];
   logic [10:0]  ra;
   always @(posedge clk) begin
      ap[0] <= ram_raddr;
      for (int i = 1; i < RAM_LAT; i++) ap[i] <= ap[i-1];
   end
   assign ra        = ap[RAM_LAT-1];
   assign ram_rdata = mem[ra[10:7]][ra[6:0]];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard
   logic [133:0] exp_q[$];
   logic [8:0]   rel_q[$];
   int  n_cmp = 0, n_bad = 0;
   int  rd_cnt, acc_cyc;
   logic [7:0] cur_id;
   bit  head_pend = 0, chk_lat = 0;

   task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s", nm);
   endtask

   logic [133:0] e;
   logic [8:0]   r;
   always @(negedge clk) begin
      if (!rst) begin
         if (ram_rd) begin
            chk("rd_while_alf", 134'(in_pkt_alf), 134'(0));
            chk("raddr", 134'({rd_cnt < 128, ram_raddr}), 134'({1'b1, cur_id[3:0], rd_cnt[6:0]}));
            rd_cnt++;
         end
         if (out_pkt_data_wr) begin
            if (exp_q.size() == 0) fail("unexpected_word");
            else begin
               e = exp_q.pop_front();
               chk("data", out_pkt_data, e);
            end
            if (head_pend) begin
               head_pend = 0;
               if (chk_lat) chk("head_latency", 134'(cyc - acc_cyc), 134'(RAM_LAT));
            end
         end
         if (out_id_release_wr || out_pkt_valid_wr) begin
            chk("strobe_pair", 134'(out_pkt_valid_wr), 134'(out_id_release_wr));
            if (rel_q.size() == 0) fail("unexpected_release");
            else begin
               r = rel_q.pop_front();
               chk("release", 134'({out_id_release, out_pkt_valid}), 134'(r));
            end
         end
      end
   end

   function automatic logic [133:0] mkw(input logic [1:0] f);
      logic [3:0] vb;
      vb = 4'($urandom);
      return {f, vb, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // kind 0: head, bodies, tail at len-1 (len>=2); 1: bad head; 2: 128 words, no tail
   task automatic load(input int s, input int kind, input int len);
      for (int w = 0; w < 128; w++) mem[s][w] = mkw(2'($urandom_range(0, 3)));
      case (kind)
         0: begin
            mem[s][0] = mkw(2'b01);
            for (int w = 1; w < len - 1; w++) mem[s][w] = mkw(2'b11);
            mem[s][len-1] = mkw(2'b10);
         end
         1: mem[s][0] = mkw((($urandom_range(0, 2) == 0) ? 2'b00 :
                              ($urandom_range(0, 1) == 0) ? 2'b11 : 2'b10));
         default: begin
            mem[s][0] = mkw(2'b01);
            for (int w = 1; w < 128; w++) mem[s][w] = mkw(2'b11);
         end
      endcase
   endtask

   // Reference: packet = words from a good head up to the first tail; no tail by the end of the
   // slot closes the packet on its last word with the tail flag and marks it bad.
   task automatic model(input logic [7:0] id, output int n);
      logic [133:0] w;
      logic         good;
      int           s;
      s = int'(id[3:0]);
      n = 0;
      good = 1'b0;
      if (mem[s][0][133:132] == 2'b01) begin
         for (int i = 0; i < 128; i++) begin
            w = mem[s][i];
            if (w[133:132] == 2'b10) begin
               exp_q.push_back(w); n++; good = 1'b1;
               break;
            end
            if (i == 127) begin
               w[133:132] = 2'b10;
               exp_q.push_back(w); n++;
            end else begin
               exp_q.push_back(w); n++;
            end
         end
      end
      rel_q.push_back({id, good});
   endtask

   task automatic accept(input logic [7:0] id);
      int k;
      for (k = 0; k < 50; k++) begin
         @(negedge clk);
         if (out_pkt_id_ready) break;
      end
      if (k == 50) fail("ready_timeout");
      cur_id = id;
      rd_cnt = 0;
      in_pkt_id = id;
      in_pkt_id_wr = 1'b1;
      @(posedge clk);
      #1;
      in_pkt_id_wr = 1'b0;
      in_pkt_id = 8'($urandom);
      acc_cyc = cyc;
   endtask

   task automatic send(input logic [7:0] id, input int kind, input int len,
                       input bit lat, input bit alf_rnd, input int as, input int al);
      int n, k;
      load(int'(id[3:0]), kind, len);
      model(id, n);
      accept(id);
      head_pend = (n != 0);
      chk_lat = lat;
      @(negedge clk);
      chk("ready_drop", 134'(out_pkt_id_ready), 134'(0));
      for (k = 0; k < 2000; k++) begin
         @(posedge clk);
         #1;
         in_pkt_alf = (k >= as && k < as + al) || (alf_rnd && $urandom_range(0, 3) == 0);
         @(negedge clk);
         if (out_id_release_wr) break;
      end
      if (k == 2000) fail("release_timeout");
      in_pkt_alf = 1'b0;
      chk_lat = 0;
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_ready"}, 134'(out_pkt_id_ready), 134'(1));
      chk({nm, "_strobes"}, 134'({ram_rd, out_pkt_data_wr, out_pkt_valid_wr, out_id_release_wr,
                                  out_pkt_valid}), 134'(0));
      chk({nm, "_data"}, out_pkt_data, 134'(0));
      chk({nm, "_addr_rel"}, 134'({ram_raddr, out_id_release}), 134'(0));
   endtask

   initial begin
      rst = 1'b1;
      in_pkt_id = 8'h00;
      in_pkt_id_wr = 1'b0;
      in_pkt_alf = 1'b0;
      for (int s = 0; s < 16; s++)
         for (int w = 0; w < 128; w++) mem[s][w] = '0;
      for (int i = 0; i < RAM_LAT; i++) ap[i] = '0;
      repeat (3) @(negedge clk);
      chk_idle("reset");
      @(posedge clk); #1; rst = 1'b0;

      send(8'h05, 0, 3, 1, 0, 1000, 0);     // basic 3-word packet, latency checked
      send(8'h3A, 0, 10, 0, 0, 3, 5);       // alf held 5 cycles mid-packet
      send(8'h42, 0, 2, 0, 0, 1000, 0);     // head then tail
      send(8'h97, 1, 0, 0, 0, 1000, 0);     // bad head
      send(8'hC6, 2, 128, 0, 0, 1000, 0);   // no tail within the slot
      send(8'h2D, 0, 128, 0, 1, 1000, 0);   // tail on the very last word

      // Reset during READ: nothing from this packet may come out, no release.
      load(15, 0, 20);
      accept(8'h0F);
      @(posedge clk); #1; rst = 1'b1;
      @(negedge clk);
      chk_idle("midreset");
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      repeat (8) @(negedge clk);
      chk_idle("after_reset");

      send(8'h0F, 0, 4, 1, 0, 1000, 0);

      for (int p = 0; p < 25; p++) begin
         int kd, ln;
         kd = ($urandom_range(0, 9) < 7) ? 0 : ($urandom_range(0, 1) == 0 ? 1 : 2);
         ln = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 128)) : int'($urandom_range(2, 30));
         send(8'($urandom), kd, ln, 0, 1, 1000, 0);
      end

      repeat (5) @(negedge clk);
      chk("words_left", 134'(exp_q.size()), 134'(0));
      chk("releases_left", 134'(rel_q.size()), 134'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
